// File: rtl/verbus_master_pkg.sv
// Shared types and helpers for the verbus load/store master: FSM states,
// access sizes and the alignment rule applied before a request reaches the bus.
package verbus_master_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } bus_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } access_size_t;

  // Only the two low address bits decide alignment, so only those are passed in.
  function automatic logic is_aligned(input logic [1:0] addr_lsb, input access_size_t size);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lsb[0];
      SIZE_WORD: return (addr_lsb == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/verbus_master_if.sv
// Memory-side valid/ready bus between the verbus master and its slave.
interface verbus_master_if;
  import verbus_master_pkg::*;

  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_address;
  logic [STRB_W-1:0] bus_wstrobe;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_address, bus_wstrobe, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_address, bus_wstrobe, bus_wdata,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/verbus_master_timer.sv
// Wait-state counter for an outstanding bus request; flags the last permitted
// cycle before the request is abandoned. LIMIT of 0 never expires.
module verbus_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

  logic [CNT_W-1:0] r_count;

  // Saturates instead of wrapping so a disabled timeout cannot fire spuriously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (LIMIT > 0) && (r_count == CNT_LAST);

endmodule

// File: rtl/verbus_master.sv
// Core-side load/store bus master: validates an aligned request, runs one
// valid/ready bus transaction, returns registered load data and pulses done/fault.
module verbus_master
  import verbus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [STRB_W-1:0] req_wstrobe,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] load_rdata,
  verbus_master_if.master   bus
);

  bus_state_t        r_state;
  bus_state_t        w_state_nxt;
  logic              r_fault;
  logic              w_fault_nxt;
  logic              w_latch;
  logic              w_capture;
  logic              w_expired;
  logic              w_timer_clear;
  logic              w_timer_en;
  logic              r_is_load;
  logic [ADDR_W-1:2] r_addr_word;
  logic [STRB_W-1:0] r_wstrobe;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_load_rdata;

  assign w_timer_clear = (r_state != REQ);
  assign w_timer_en    = (r_state == REQ) && !bus.bus_ready;

  verbus_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Requests are only looked at in IDLE; ready on the last timed edge still completes.
  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_load && req_store) begin
          w_fault_nxt = 1'b1;
        end else if (req_load || req_store) begin
          if (is_aligned(req_address[1:0], access_size_t'(req_size))) begin
            w_latch     = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_fault_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.bus_ready) begin
          w_state_nxt = DONE;
        end else if (w_expired) begin
          w_state_nxt = IDLE;
          w_fault_nxt = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_capture = (r_state == REQ) && bus.bus_ready && r_is_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_load    <= 1'b0;
      r_addr_word  <= '0;
      r_wstrobe    <= '0;
      r_wdata      <= '0;
      r_load_rdata <= '0;
    end else begin
      if (w_latch) begin
        r_is_load   <= req_load;
        r_addr_word <= req_address[ADDR_W-1:2];
        r_wstrobe   <= req_load ? '0 : req_wstrobe;
        r_wdata     <= req_wdata;
      end
      if (w_capture) begin
        r_load_rdata <= bus.bus_rdata;
      end
    end
  end

  assign busy            = (r_state == REQ);
  assign done            = (r_state == DONE);
  assign fault           = r_fault;
  assign load_rdata      = r_load_rdata;
  assign bus.bus_valid   = (r_state == REQ);
  assign bus.bus_address = {r_addr_word, 2'b00};
  assign bus.bus_wstrobe = r_wstrobe;
  assign bus.bus_wdata   = r_wdata;

endmodule

// File: tb/tb_verbus_master.sv
// Scoreboard bench for verbus_master: requests push expected responses, a bus
// slave follows per-request wait plans, and a monitor checks every DUT response.
module tb_verbus_master;
  import verbus_master_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_address = 32'd0;
  logic [3:0]  req_wstrobe = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_rdata;

  verbus_master_if bus_if();

  verbus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_address(req_address),
    .req_wstrobe(req_wstrobe),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_rdata (load_rdata),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    bit          is_load;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          vcycles;
    int          resp_cyc;
  } exp_t;

  typedef struct {
    int          wt;
    logic [31:0] rd;
  } plan_t;

  exp_t        exp_q[$];
  plan_t       plan_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          vcount = 0;
  int          issued = 0;
  int          responses = 0;
  logic [31:0] model_rdata = 32'd0;
  bit          s_active = 1'b0;
  int          s_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave: asserts ready once the planned number of wait cycles has elapsed.
  initial begin
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = 32'd0;
  end

  always @(negedge clk) begin
    if (!bus_if.bus_valid) begin
      if (s_active && plan_q.size() > 0) plan_q.delete(0);
      s_active = 1'b0;
      bus_if.bus_ready = 1'b0;
      bus_if.bus_rdata = $urandom;
    end else begin
      if (!s_active) begin
        s_active = 1'b1;
        s_cnt = 0;
      end
      if (plan_q.size() > 0 && s_cnt == plan_q[0].wt) begin
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = plan_q[0].rd;
      end else begin
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = $urandom;
      end
      s_cnt++;
    end
  end

  // Monitor: pops the scoreboard whenever done or fault is presented.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("busy_vs_valid", {31'd0, busy}, {31'd0, bus_if.bus_valid});
      check("done_and_fault", {31'd0, done & fault}, 32'd0);
      check("fault_while_busy", {31'd0, fault & busy}, 32'd0);
      if (bus_if.bus_valid) begin
        vcount++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid=1 required no outstanding request");
        end else begin
          check("bus_address", bus_if.bus_address, exp_q[0].addr);
          check("bus_wstrobe", {28'd0, bus_if.bus_wstrobe}, {28'd0, exp_q[0].strb});
          check("bus_wdata", bus_if.bus_wdata, exp_q[0].wdata);
        end
      end
      if (done || fault) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_response: got done=%b fault=%b required none", done, fault);
        end else begin
          e = exp_q.pop_front();
          check("resp_is_fault", {31'd0, fault}, {31'd0, e.is_fault});
          check("resp_cycle", cyc, e.resp_cyc);
          check("valid_cycles", vcount, e.vcycles);
          if (!e.is_fault && e.is_load) model_rdata = e.rd;
        end
        vcount = 0;
        responses++;
      end
      check("load_rdata", load_rdata, model_rdata);
    end
  end

  task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd, input int wt,
                       input logic [31:0] rd);
    exp_t  e;
    plan_t p;
    @(negedge clk);
    req_load = ld;
    req_store = st;
    req_size = sz;
    req_address = addr;
    req_wstrobe = strb;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_load = 1'b0;
    req_store = 1'b0;
    req_size = 2'($urandom);
    req_address = $urandom;
    req_wstrobe = 4'($urandom);
    req_wdata = $urandom;
    e.is_load = ld;
    e.rd = rd;
    e.addr = addr & 32'hFFFF_FFFC;
    e.strb = ld ? 4'b0000 : strb;
    e.wdata = wd;
    if (ld && st) begin
      e.is_fault = 1'b1;
      e.vcycles = 0;
      e.resp_cyc = cyc;
    end else if (sz == 2'd3 || (addr % (32'd1 << sz)) != 0) begin
      e.is_fault = 1'b1;
      e.vcycles = 0;
      e.resp_cyc = cyc;
    end else begin
      p.wt = wt;
      p.rd = rd;
      plan_q.push_back(p);
      if (wt >= TO) begin
        e.is_fault = 1'b1;
        e.vcycles = TO;
        e.resp_cyc = cyc + TO;
      end else begin
        e.is_fault = 1'b0;
        e.vcycles = wt + 1;
        e.resp_cyc = cyc + 1 + wt;
      end
    end
    exp_q.push_back(e);
    issued++;
  endtask

  task automatic wait_resp();
    int t = 0;
    while (responses != issued && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (responses != issued) begin
      n_fail++;
      $display("FAIL response_timeout: got %0d responses required %0d", responses, issued);
      exp_q.delete();
      responses = issued;
    end
  endtask

  task automatic run(input bit ld, input bit st, input logic [1:0] sz, input logic [31:0] addr,
                     input logic [3:0] strb, input logic [31:0] wd, input int wt,
                     input logic [31:0] rd);
    issue(ld, st, sz, addr, strb, wd, wt, rd);
    wait_resp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ld;
    bit          st;
    logic [1:0]  sz;
    logic [31:0] addr;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_valid", {31'd0, bus_if.bus_valid}, 32'd0);
    check("rst_load_rdata", load_rdata, 32'd0);
    check("rst_bus_address", bus_if.bus_address, 32'd0);
    check("rst_bus_wstrobe", {28'd0, bus_if.bus_wstrobe}, 32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    reset = 1'b1;

    run(1, 0, 2'd2, 32'h100, 4'hF, 32'h0, 3, 32'hDEADBEEF);
    run(0, 1, 2'd0, 32'h203, 4'b1000, 32'h5A5A5A5A, 0, 32'h11111111);
    run(1, 0, 2'd1, 32'h101, 4'h0, 32'h0, 0, 32'h22222222);
    run(0, 1, 2'd2, 32'h102, 4'hF, 32'h0BADF00D, 0, 32'h0);
    run(1, 0, 2'd2, 32'h500, 4'h0, 32'h0, TO, 32'h33333333);
    run(1, 0, 2'd2, 32'h504, 4'h0, 32'h0, TO - 1, 32'h44444444);
    run(1, 1, 2'd2, 32'h600, 4'hF, 32'h0, 0, 32'h55555555);
    run(1, 0, 2'd3, 32'h700, 4'h0, 32'h0, 0, 32'h66666666);
    for (int i = 0; i < 3; i++) run(1, 0, 2'd2, 32'h800 + 32'(4 * i), 4'h0, 32'h0, 0, 32'hA0000000 + 32'(i));

    // Asynchronous reset in the middle of an outstanding request.
    issue(1, 0, 2'd2, 32'h300, 4'h0, 32'h0, 3, 32'h12345678);
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, bus_if.bus_valid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus_if.bus_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done_fault", {30'd0, done, fault}, 32'd0);
    check("mid_rst_load_rdata", load_rdata, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    plan_q.delete();
    vcount = 0;
    model_rdata = 32'd0;
    responses = issued;
    @(negedge clk);
    reset = 1'b1;
    run(1, 0, 2'd2, 32'h400, 4'h0, 32'h0, 1, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       begin ld = 1'b1; st = 1'b1; end
        1, 2, 3, 4: begin ld = 1'b0; st = 1'b1; end
        default: begin ld = 1'b1; st = 1'b0; end
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'b00;
      end
      run(ld, st, sz, addr, 4'($urandom), $urandom, $urandom_range(0, TO + 1), $urandom);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
